// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// if_prefetch_queue -- instruction prefetch FIFO with in-order fetch tagging
//                      and flush-time discard of in-flight memory requests.
// Revision: 1.0
// ============================================================================
module if_prefetch_queue #(
  parameter int unsigned      width          = 32,
  parameter int unsigned      depth          = 4,
  parameter logic [width-1:0] resetAddr      = '0,
  parameter int unsigned      maxOutstanding = 2
) (
  input  logic             clk,
  input  logic             resetN,
  output logic             memReq,
  output logic [width-1:0] memAddr,
  input  logic             memAck,
  input  logic             memValid,
  input  logic [width-1:0] memData,
  input  logic             stall,
  input  logic             flush,
  input  logic [width-1:0] flushAddr,
  output logic             validOut,
  output logic [width-1:0] instructionOut,
  output logic [width-1:0] PCOut
);

  localparam int unsigned c_PTR_W = $clog2(depth);
  localparam int unsigned c_CNT_W = $clog2(depth + 1);
  localparam int unsigned c_OUT_W = $clog2(maxOutstanding + 1);
  localparam int unsigned c_TAG_W = (maxOutstanding > 1) ? $clog2(maxOutstanding) : 1;
  localparam int unsigned c_SUM_W = c_CNT_W + c_OUT_W + 1;

  logic [width-1:0]   fetchPc_q, fetchPc_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic [c_OUT_W-1:0] outstanding_q, outstanding_d;
  logic [c_OUT_W-1:0] discard_q, discard_d;
  logic [c_PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [c_TAG_W-1:0] tagWr_q, tagWr_d, tagRd_q, tagRd_d;

  logic [width-1:0] instMem_q [depth];
  logic [width-1:0] pcMem_q   [depth];
  logic [width-1:0] tagMem_q  [maxOutstanding];

  logic               w_credit;
  logic               w_accept;
  logic               w_rsp;
  logic               w_push;
  logic               w_pop;
  logic [c_OUT_W-1:0] w_live;

  // discard never exceeds outstanding, so the difference is the count of
  // responses that will still land in the FIFO.
  assign w_live   = outstanding_q - discard_q;
  assign w_credit = (c_SUM_W'(count_q) + c_SUM_W'(w_live)) < c_SUM_W'(depth);

  assign memReq   = resetN && !flush && w_credit &&
                    (outstanding_q < c_OUT_W'(maxOutstanding));
  assign memAddr  = fetchPc_q;

  assign validOut       = resetN && (count_q != '0);
  assign instructionOut = validOut ? instMem_q[rdPtr_q] : '0;
  assign PCOut          = validOut ? pcMem_q[rdPtr_q]   : '0;

  assign w_accept = memReq && memAck;
  assign w_rsp    = memValid && (outstanding_q != '0);
  assign w_push   = w_rsp && !flush && (discard_q == '0);
  assign w_pop    = validOut && !stall && !flush;

  function automatic logic [c_TAG_W-1:0] tagNext(input logic [c_TAG_W-1:0] p);
    return (p == c_TAG_W'(maxOutstanding - 1)) ? '0 : p + c_TAG_W'(1);
  endfunction

  always_comb begin
    fetchPc_d     = fetchPc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    tagWr_d       = tagWr_q;
    tagRd_d       = tagRd_q;

    if (w_accept) begin
      fetchPc_d     = fetchPc_q + width'(4);
      outstanding_d = outstanding_d + c_OUT_W'(1);
      tagWr_d       = tagNext(tagWr_q);
    end
    if (w_rsp) begin
      outstanding_d = outstanding_d - c_OUT_W'(1);
      tagRd_d       = tagNext(tagRd_q);
      if (discard_q != '0) discard_d = discard_q - c_OUT_W'(1);
    end
    if (w_push) begin
      wrPtr_d = wrPtr_q + c_PTR_W'(1);
      count_d = count_d + c_CNT_W'(1);
    end
    if (w_pop) begin
      rdPtr_d = rdPtr_q + c_PTR_W'(1);
      count_d = count_d - c_CNT_W'(1);
    end

    // Tags stay queued on a redirect: the stale responses still arrive in
    // order and must consume their slots while being discarded.
    if (flush) begin
      fetchPc_d = flushAddr & ~width'(3);
      count_d   = '0;
      wrPtr_d   = '0;
      rdPtr_d   = '0;
      discard_d = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      fetchPc_q     <= resetAddr;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      tagWr_q       <= '0;
      tagRd_q       <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      tagWr_q       <= tagWr_d;
      tagRd_q       <= tagRd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN && w_accept) tagMem_q[tagWr_q] <= fetchPc_q;
    if (resetN && w_push) begin
      instMem_q[wrPtr_q] <= memData;
      pcMem_q[wrPtr_q]   <= tagMem_q[tagRd_q];
    end
  end

  a_noSpuriousRsp: assert property (@(posedge clk) disable iff (!resetN)
                                    memValid |-> (outstanding_q != '0));

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// tb_if_prefetch_queue -- randomized bench against a queue-level reference
// model of the prefetch queue and a variable-latency in-order memory.
module tb_if_prefetch_queue;
  localparam int          D  = 4;
  localparam int          MO = 2;
  localparam logic [31:0] RA = 32'h0;

  logic        clk = 1'b0;
  logic        resetN, memReq, memAck, memValid, stall, flush, validOut;
  logic [31:0] memAddr, memData, flushAddr, instructionOut, PCOut;

  always #5 clk = ~clk;

  if_prefetch_queue #(
    .width(32), .depth(D), .resetAddr(RA), .maxOutstanding(MO)
  ) dut (
    .clk(clk), .resetN(resetN), .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memValid(memValid), .memData(memData),
    .stall(stall), .flush(flush), .flushAddr(flushAddr),
    .validOut(validOut), .instructionOut(instructionOut), .PCOut(PCOut)
  );

  typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int ready; } req_t;

  ent_t        fifo[$];   // instructions delivered but not yet consumed
  req_t        infl[$];   // requests accepted by memory, oldest first
  logic [31:0] mPc;
  int          mDisc;
  int          cyc;
  int          nVec, nBad;
  int unsigned ackPct, rspPct, stallPct, flushPct, rstPct, latMax;
  logic        forceFlush, forceRst;
  logic [31:0] forceAddr;
  logic        eReq, eValid;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    req_t        r;
    int unsigned lat;
    @(negedge clk);
    resetN    = !(forceRst || ($urandom_range(99) < rstPct));
    flush     = resetN && (forceFlush || ($urandom_range(99) < flushPct));
    flushAddr = forceFlush ? forceAddr : $urandom;
    stall     = $urandom_range(99) < stallPct;
    memAck    = $urandom_range(99) < ackPct;
    memValid  = resetN && (infl.size() > 0) && (infl[0].ready <= cyc) &&
                ($urandom_range(99) < rspPct);
    memData   = memValid ? memWord(infl[0].addr) : $urandom;
    forceFlush = 1'b0;
    forceRst   = 1'b0;
    #1;
    eValid = resetN && (fifo.size() > 0);
    eReq   = resetN && !flush && (fifo.size() + infl.size() - mDisc < D) &&
             (infl.size() < MO);
    chk("memReq", {31'b0, memReq}, {31'b0, eReq});
    chk("validOut", {31'b0, validOut}, {31'b0, eValid});
    if (eReq) chk("memAddr", memAddr, mPc);
    if (eValid) begin
      chk("PCOut", PCOut, fifo[0].pc);
      chk("instructionOut", instructionOut, fifo[0].ins);
    end
    @(posedge clk);
    cyc++;
    if (!resetN) begin
      mPc = RA;
      fifo.delete();
      infl.delete();
      mDisc = 0;
    end else begin
      if (eValid && !stall && !flush) void'(fifo.pop_front());
      if (memValid) begin
        r = infl.pop_front();
        if (!flush && mDisc > 0) mDisc--;
        else if (!flush) fifo.push_back('{memData, r.addr});
      end
      if (eReq && memAck) begin
        lat = $urandom_range(latMax, 1);
        infl.push_back('{mPc, cyc + int'(lat) - 1});
        mPc = mPc + 32'd4;
      end
      if (flush) begin
        fifo.delete();
        mPc   = flushAddr & ~32'h3;
        mDisc = infl.size();
      end
    end
  endtask

  initial begin
    resetN = 1'b0; memAck = 1'b0; memValid = 1'b0; memData = '0;
    stall = 1'b0; flush = 1'b0; flushAddr = '0;
    forceFlush = 1'b0; forceRst = 1'b0; forceAddr = '0;
    mPc = RA; mDisc = 0; cyc = 0; nVec = 0; nBad = 0;
    ackPct = 100; rspPct = 100; stallPct = 0; flushPct = 0; rstPct = 0; latMax = 1;

    // Streaming fetch, single-cycle memory, no stalls
    forceRst = 1'b1; step();
    forceRst = 1'b1; step();
    repeat (12) step();

    // Consumer stalled from reset until the FIFO fills, then released
    forceRst = 1'b1; step();
    stallPct = 100; repeat (10) step();
    stallPct = 0;   repeat (8) step();

    // Redirect to an unaligned target with two requests in flight
    forceRst = 1'b1; step();
    latMax = 3; repeat (3) step();
    forceFlush = 1'b1; forceAddr = 32'h0000_0103; step();
    repeat (10) step();

    // Fetch address wraps past the top of the address space
    latMax = 1;
    forceFlush = 1'b1; forceAddr = 32'hFFFF_FFF8; step();
    repeat (8) step();

    // Memory withholds acceptance, then accepts
    ackPct = 0;   repeat (5) step();
    ackPct = 100; repeat (6) step();

    // Reset with a partly full FIFO and requests in flight
    stallPct = 100; latMax = 4; repeat (4) step();
    forceRst = 1'b1; step();
    stallPct = 0; latMax = 1; repeat (6) step();

    // Randomized traffic with periodically reshuffled knobs
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        ackPct   = $urandom_range(100, 20);
        rspPct   = $urandom_range(100, 30);
        stallPct = $urandom_range(70, 0);
        flushPct = $urandom_range(10, 0);
        rstPct   = $urandom_range(2, 0);
        latMax   = $urandom_range(4, 1);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
`default_nettype wire
